// File: rtl/tank_game_pkg.sv
// Shared types and constants for the tank game bullet engine.
package tank_game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } pool_state_e;

    localparam int TILE_W         = 32;
    localparam int GRID_MAX_X_DEF = 640 / TILE_W - 1;
    localparam int GRID_MAX_Y_DEF = 480 / TILE_W - 1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position/direction/owner registers, edge-retire check and one-tile step.
module bullet_slot
    import tank_game_pkg::*;
#(
    parameter int POS_W      = 5,
    parameter int TGT_W      = 3,
    parameter int GRID_MAX_X = GRID_MAX_X_DEF,
    parameter int GRID_MAX_Y = GRID_MAX_Y_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             kill_i,
    input  logic             step_i,
    input  logic [POS_W-1:0] x_i,
    input  logic [POS_W-1:0] y_i,
    input  logic [1:0]       dir_i,
    input  logic [TGT_W-1:0] owner_i,
    output logic             active_o,
    output logic [POS_W-1:0] x_o,
    output logic [POS_W-1:0] y_o,
    output logic [1:0]       dir_o,
    output logic [TGT_W-1:0] owner_o
);

    localparam logic [POS_W-1:0] MAX_X = POS_W'(GRID_MAX_X);
    localparam logic [POS_W-1:0] MAX_Y = POS_W'(GRID_MAX_Y);

    logic             active_q, active_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]       dir_q, dir_d;
    logic [TGT_W-1:0] owner_q, owner_d;
    logic             at_edge;
    logic             off_grid;

    // A bullet spawned off-grid retires on its first step, whatever its direction.
    always_comb begin
        off_grid = (x_q > MAX_X) || (y_q > MAX_Y);
        case (dir_q)
            DIR_UP:    at_edge = (y_q == {POS_W{1'b0}});
            DIR_DOWN:  at_edge = (y_q == MAX_Y);
            DIR_LEFT:  at_edge = (x_q == {POS_W{1'b0}});
            DIR_RIGHT: at_edge = (x_q == MAX_X);
            default:   at_edge = 1'b0;
        endcase
    end

    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        owner_d  = owner_q;
        if (load_i) begin
            active_d = 1'b1;
            x_d      = x_i;
            y_d      = y_i;
            dir_d    = dir_i;
            owner_d  = owner_i;
        end else if (kill_i) begin
            active_d = 1'b0;
        end else if (step_i && active_q) begin
            if (at_edge || off_grid) begin
                active_d = 1'b0;
            end else begin
                case (dir_q)
                    DIR_UP:    y_d = y_q - POS_W'(1);
                    DIR_DOWN:  y_d = y_q + POS_W'(1);
                    DIR_LEFT:  x_d = x_q - POS_W'(1);
                    DIR_RIGHT: x_d = x_q + POS_W'(1);
                    default:   x_d = x_q;
                endcase
            end
        end else begin
            active_d = active_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            x_q      <= {POS_W{1'b0}};
            y_q      <= {POS_W{1'b0}};
            dir_q    <= 2'b00;
            owner_q  <= {TGT_W{1'b0}};
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            owner_q  <= owner_d;
        end
    end

    assign active_o = active_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign dir_o    = dir_q;
    assign owner_o  = owner_q;

endmodule

// File: rtl/bullet_pool.sv
// Multi-bullet engine: slot allocation with cooldown, per-tick movement and a
// one-slot-per-cycle collision scan reporting bullet/tank hits.
module bullet_pool
    import tank_game_pkg::*;
#(
    parameter int NUM_BUL    = 4,
    parameter int NUM_TGT    = 5,
    parameter int POS_W      = 5,
    parameter int GRID_MAX_X = GRID_MAX_X_DEF,
    parameter int GRID_MAX_Y = GRID_MAX_Y_DEF,
    parameter int COOLDOWN   = 2,
    parameter int BUL_CANCEL = 1,
    localparam int TGT_W     = clog2_min1(NUM_TGT),
    localparam int BUL_W     = clog2_min1(NUM_BUL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     move_tick,
    input  logic                     fire_req,
    input  logic [1:0]               fire_dir,
    input  logic [POS_W-1:0]         fire_x,
    input  logic [POS_W-1:0]         fire_y,
    input  logic [TGT_W-1:0]         fire_owner,
    output logic                     fire_ack,
    output logic                     fire_drop,
    input  logic [NUM_TGT*POS_W-1:0] tgt_x,
    input  logic [NUM_TGT*POS_W-1:0] tgt_y,
    input  logic [NUM_TGT-1:0]       tgt_alive,
    output logic [NUM_BUL-1:0]       bul_active,
    output logic [NUM_BUL*POS_W-1:0] bul_x,
    output logic [NUM_BUL*POS_W-1:0] bul_y,
    output logic [NUM_BUL*2-1:0]     bul_dir,
    output logic                     hit_valid,
    output logic [BUL_W-1:0]         hit_bul,
    output logic [TGT_W-1:0]         hit_tgt,
    output logic                     scan_busy
);

    localparam int              CD_W    = clog2_min1(COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [BUL_W-1:0] LAST_IDX = BUL_W'(NUM_BUL - 1);

    pool_state_e      state_q, state_d;
    logic [BUL_W-1:0] scan_idx_q, scan_idx_d;
    logic             pend_q, pend_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             fire_ack_q, fire_ack_d;
    logic             fire_drop_q, fire_drop_d;
    logic             hit_valid_q, hit_valid_d;
    logic [BUL_W-1:0] hit_bul_q, hit_bul_d;
    logic [TGT_W-1:0] hit_tgt_q, hit_tgt_d;

    logic               step;
    logic               free_found;
    logic [NUM_BUL-1:0] load;
    logic [NUM_BUL-1:0] kill;
    logic [NUM_BUL-1:0] clash;
    logic [NUM_TGT-1:0] match;
    logic [POS_W-1:0]   cur_x, cur_y;
    logic [TGT_W-1:0]   cur_own;

    logic [NUM_BUL-1:0] slot_act;
    logic [POS_W-1:0]   slot_x   [NUM_BUL];
    logic [POS_W-1:0]   slot_y   [NUM_BUL];
    logic [1:0]         slot_dir [NUM_BUL];
    logic [TGT_W-1:0]   slot_own [NUM_BUL];

    for (genvar g = 0; g < NUM_BUL; g++) begin : g_slot
        bullet_slot #(
            .POS_W      (POS_W),
            .TGT_W      (TGT_W),
            .GRID_MAX_X (GRID_MAX_X),
            .GRID_MAX_Y (GRID_MAX_Y)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load[g]),
            .kill_i   (kill[g]),
            .step_i   (step),
            .x_i      (fire_x),
            .y_i      (fire_y),
            .dir_i    (fire_dir),
            .owner_i  (fire_owner),
            .active_o (slot_act[g]),
            .x_o      (slot_x[g]),
            .y_o      (slot_y[g]),
            .dir_o    (slot_dir[g]),
            .owner_o  (slot_own[g])
        );
        assign bul_x[g*POS_W +: POS_W] = slot_x[g];
        assign bul_y[g*POS_W +: POS_W] = slot_y[g];
        assign bul_dir[g*2 +: 2]       = slot_dir[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            scan_idx_q <= {BUL_W{1'b0}};
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            pend_q     <= pend_d;
        end
    end

    // A tick that lands during a scan is remembered once and replayed right after.
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        pend_d     = pend_q;
        step       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (move_tick || pend_q) begin
                    step       = 1'b1;
                    pend_d     = 1'b0;
                    state_d    = ST_SCAN;
                    scan_idx_d = {BUL_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                pend_d = pend_q | move_tick;
                if (scan_idx_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    scan_idx_d = {BUL_W{1'b0}};
                end else begin
                    scan_idx_d = scan_idx_q + BUL_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                scan_idx_d = {BUL_W{1'b0}};
                pend_d     = 1'b0;
            end
        endcase
    end

    assign scan_busy = (state_q == ST_SCAN);

    // Allocation looks at registered activity, so a slot freed this cycle is reusable next cycle.
    always_comb begin
        load        = {NUM_BUL{1'b0}};
        free_found  = 1'b0;
        fire_ack_d  = 1'b0;
        fire_drop_d = 1'b0;
        cd_d        = (step && (cd_q != {CD_W{1'b0}})) ? cd_q - CD_W'(1) : cd_q;
        if (fire_req && (cd_q == {CD_W{1'b0}})) begin
            for (int i = 0; i < NUM_BUL; i++) begin
                load[i]    = !slot_act[i] && !free_found;
                free_found = free_found | !slot_act[i];
            end
            if (free_found) begin
                fire_ack_d = 1'b1;
                cd_d       = CD_LOAD;
            end else begin
                fire_drop_d = 1'b1;
            end
        end else begin
            free_found = 1'b0;
        end
    end

    always_comb begin
        kill        = {NUM_BUL{1'b0}};
        hit_valid_d = 1'b0;
        hit_bul_d   = {BUL_W{1'b0}};
        hit_tgt_d   = {TGT_W{1'b0}};
        cur_x       = slot_x[scan_idx_q];
        cur_y       = slot_y[scan_idx_q];
        cur_own     = slot_own[scan_idx_q];
        for (int t = 0; t < NUM_TGT; t++) begin
            match[t] = tgt_alive[t] && (TGT_W'(t) != cur_own)
                       && (tgt_x[t*POS_W +: POS_W] == cur_x)
                       && (tgt_y[t*POS_W +: POS_W] == cur_y);
        end
        for (int t = NUM_TGT - 1; t >= 0; t--) begin
            hit_tgt_d = match[t] ? TGT_W'(t) : hit_tgt_d;
        end
        for (int j = 0; j < NUM_BUL; j++) begin
            clash[j] = (BUL_CANCEL != 0) && (j != int'(scan_idx_q)) && slot_act[j]
                       && (slot_x[j] == cur_x) && (slot_y[j] == cur_y);
        end
        if (scan_busy && slot_act[scan_idx_q]) begin
            if (|match) begin
                kill[scan_idx_q] = 1'b1;
                hit_valid_d      = 1'b1;
                hit_bul_d        = scan_idx_q;
            end else if (|clash) begin
                kill             = clash;
                kill[scan_idx_q] = 1'b1;
            end else begin
                kill = {NUM_BUL{1'b0}};
            end
        end else begin
            kill = {NUM_BUL{1'b0}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cd_q        <= {CD_W{1'b0}};
            fire_ack_q  <= 1'b0;
            fire_drop_q <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_bul_q   <= {BUL_W{1'b0}};
            hit_tgt_q   <= {TGT_W{1'b0}};
        end else begin
            cd_q        <= cd_d;
            fire_ack_q  <= fire_ack_d;
            fire_drop_q <= fire_drop_d;
            hit_valid_q <= hit_valid_d;
            hit_bul_q   <= hit_bul_d;
            hit_tgt_q   <= hit_tgt_d;
        end
    end

    assign fire_ack   = fire_ack_q;
    assign fire_drop  = fire_drop_q;
    assign hit_valid  = hit_valid_q;
    assign hit_bul    = hit_bul_q;
    assign hit_tgt    = hit_tgt_q;
    assign bul_active = slot_act;

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: directed scenarios plus randomized traffic against a tile-level model.
module tb_bullet_pool;

    localparam int NB = 4;
    localparam int NT = 5;
    localparam int PW = 5;
    localparam int TW = 3;
    localparam int BW = 2;
    localparam int MX = 19;
    localparam int MY = 14;
    localparam int CD = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             move_tick = 1'b0;
    logic             fire_req = 1'b0;
    logic [1:0]       fire_dir = 2'b00;
    logic [PW-1:0]    fire_x = '0;
    logic [PW-1:0]    fire_y = '0;
    logic [TW-1:0]    fire_owner = '0;
    logic             fire_ack, fire_drop;
    logic [NT*PW-1:0] tgt_x = '0;
    logic [NT*PW-1:0] tgt_y = '0;
    logic [NT-1:0]    tgt_alive = '0;
    logic [NB-1:0]    bul_active;
    logic [NB*PW-1:0] bul_x, bul_y;
    logic [NB*2-1:0]  bul_dir;
    logic             hit_valid;
    logic [BW-1:0]    hit_bul;
    logic [TW-1:0]    hit_tgt;
    logic             scan_busy;

    bullet_pool dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .fire_req(fire_req),
        .fire_dir(fire_dir), .fire_x(fire_x), .fire_y(fire_y), .fire_owner(fire_owner),
        .fire_ack(fire_ack), .fire_drop(fire_drop), .tgt_x(tgt_x), .tgt_y(tgt_y),
        .tgt_alive(tgt_alive), .bul_active(bul_active), .bul_x(bul_x), .bul_y(bul_y),
        .bul_dir(bul_dir), .hit_valid(hit_valid), .hit_bul(hit_bul), .hit_tgt(hit_tgt),
        .scan_busy(scan_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Tile-level model: slot contents, cooldown, scan position (-1 = not scanning), pending tick.
    int m_act[NB], m_x[NB], m_y[NB], m_dir[NB], m_own[NB];
    int m_cd, m_scan, m_pend;
    int e_ack, e_drop, e_hv, e_hb, e_ht;
    int dx_of[4] = '{0, 0, -1, 1};
    int dy_of[4] = '{-1, 1, 0, 0};

    int hit_seen, last_hb, last_ht, ack_cnt, drop_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int tx(input int t);
        return int'(tgt_x[t*PW +: PW]);
    endfunction

    function automatic int ty(input int t);
        return int'(tgt_y[t*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_act[b] = 0; m_x[b] = 0; m_y[b] = 0; m_dir[b] = 0; m_own[b] = 0;
        end
        m_cd = 0; m_scan = -1; m_pend = 0;
        e_ack = 0; e_drop = 0; e_hv = 0; e_hb = 0; e_ht = 0;
    endtask

    task automatic model_edge();
        int n_act[NB], n_x[NB], n_y[NB], n_dir[NB], n_own[NB];
        int n_cd, n_scan, n_pend, nx, ny, hit, i, slot;
        if (rst) begin
            model_reset();
            return;
        end
        n_act = m_act; n_x = m_x; n_y = m_y; n_dir = m_dir; n_own = m_own;
        n_cd = m_cd; n_scan = m_scan; n_pend = m_pend;
        e_ack = 0; e_drop = 0; e_hv = 0; e_hb = 0; e_ht = 0;
        if (m_scan < 0 && (move_tick || m_pend != 0)) begin
            n_pend = 0;
            n_scan = 0;
            if (n_cd > 0) n_cd--;
            for (int b = 0; b < NB; b++) begin
                if (m_act[b] != 0) begin
                    nx = m_x[b] + dx_of[m_dir[b]];
                    ny = m_y[b] + dy_of[m_dir[b]];
                    if (nx < 0 || nx > MX || ny < 0 || ny > MY) n_act[b] = 0;
                    else begin n_x[b] = nx; n_y[b] = ny; end
                end
            end
        end else if (m_scan >= 0) begin
            if (move_tick) n_pend = 1;
            i = m_scan;
            if (m_act[i] != 0) begin
                hit = -1;
                for (int t = NT - 1; t >= 0; t--)
                    if (tgt_alive[t] && t != m_own[i] && tx(t) == m_x[i] && ty(t) == m_y[i]) hit = t;
                if (hit >= 0) begin
                    n_act[i] = 0; e_hv = 1; e_hb = i; e_ht = hit;
                end else begin
                    for (int j = 0; j < NB; j++)
                        if (j != i && m_act[j] != 0 && m_x[j] == m_x[i] && m_y[j] == m_y[i]) begin
                            n_act[j] = 0; n_act[i] = 0;
                        end
                end
            end
            n_scan = (i == NB - 1) ? -1 : i + 1;
        end
        if (fire_req && m_cd == 0) begin
            slot = -1;
            for (int b = NB - 1; b >= 0; b--) if (m_act[b] == 0) slot = b;
            if (slot >= 0) begin
                n_act[slot] = 1; n_x[slot] = int'(fire_x); n_y[slot] = int'(fire_y);
                n_dir[slot] = int'(fire_dir); n_own[slot] = int'(fire_owner);
                e_ack = 1; n_cd = CD;
            end else e_drop = 1;
        end
        m_act = n_act; m_x = n_x; m_y = n_y; m_dir = n_dir; m_own = n_own;
        m_cd = n_cd; m_scan = n_scan; m_pend = n_pend;
    endtask

    task automatic compare_all();
        int exp_act;
        exp_act = 0;
        check("fire_ack", int'(fire_ack), e_ack);
        check("fire_drop", int'(fire_drop), e_drop);
        check("hit_valid", int'(hit_valid), e_hv);
        if (e_hv != 0) begin
            check("hit_bul", int'(hit_bul), e_hb);
            check("hit_tgt", int'(hit_tgt), e_ht);
        end
        check("scan_busy", int'(scan_busy), int'(m_scan >= 0));
        for (int b = 0; b < NB; b++) begin
            if (m_act[b] != 0) begin
                exp_act = exp_act | (1 << b);
                check("bul_x", int'(bul_x[b*PW +: PW]), m_x[b]);
                check("bul_y", int'(bul_y[b*PW +: PW]), m_y[b]);
                check("bul_dir", int'(bul_dir[b*2 +: 2]), m_dir[b]);
            end
        end
        check("bul_active", int'(bul_active), exp_act);
        if (hit_valid) begin hit_seen = 1; last_hb = int'(hit_bul); last_ht = int'(hit_tgt); end
        if (fire_ack) ack_cnt++;
        if (fire_drop) drop_cnt++;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        hit_seen = 0; ack_cnt = 0; drop_cnt = 0;
    endtask

    task automatic fire(input int x, input int y, input int d, input int o);
        fire_x = x[PW-1:0]; fire_y = y[PW-1:0]; fire_dir = d[1:0]; fire_owner = o[TW-1:0];
        fire_req = 1'b1; cyc(); fire_req = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            move_tick = 1'b1; cyc(); move_tick = 1'b0;
            repeat (6) cyc();
        end
    endtask

    task automatic set_tgt(input int t, input int x, input int y);
        tgt_x[t*PW +: PW] = x[PW-1:0];
        tgt_y[t*PW +: PW] = y[PW-1:0];
    endtask

    initial begin
        model_reset();
        do_reset();
        check("rst_active", int'(bul_active), 0);
        check("rst_busy", int'(scan_busy), 0);
        check("rst_hit_bul", int'(hit_bul), 0);
        check("rst_hit_tgt", int'(hit_tgt), 0);

        // Fire right from (5,5), three steps
        fire(5, 5, 3, 0);
        check("t1_ack", int'(fire_ack), 1);
        check("t1_x0", int'(bul_x[PW-1:0]), 5);
        ticks(3);
        check("t1_x3", int'(bul_x[PW-1:0]), 8);
        check("t1_y3", int'(bul_y[PW-1:0]), 5);

        // Edge retire
        do_reset();
        fire(19, 7, 3, 0); ticks(1);
        check("t2_right_edge", int'(bul_active[0]), 0);
        do_reset();
        fire(0, 0, 0, 0); ticks(1);
        check("t2_top_edge", int'(bul_active[0]), 0);
        check("t2_no_hit", hit_seen, 0);

        // Target hit, then dead target and owner immunity
        do_reset();
        set_tgt(2, 10, 3); tgt_alive = 5'b00100;
        fire(9, 3, 3, 0); ticks(1);
        check("t3_hit", hit_seen, 1);
        check("t3_hb", last_hb, 0);
        check("t3_ht", last_ht, 2);
        check("t3_cleared", int'(bul_active[0]), 0);
        do_reset();
        tgt_alive = 5'b00000;
        fire(9, 3, 3, 0); ticks(1);
        check("t3_dead_nohit", hit_seen, 0);
        check("t3_dead_alive", int'(bul_active[0]), 1);
        do_reset();
        tgt_alive = 5'b00100;
        fire(9, 3, 3, 2); ticks(1);
        check("t3_owner_nohit", hit_seen, 0);
        check("t3_owner_alive", int'(bul_active[0]), 1);
        tgt_alive = 5'b00000;

        // Held fire with cooldown, then pool full
        do_reset();
        fire_x = 5'd2; fire_y = 5'd2; fire_dir = 2'b01; fire_owner = 3'd0;
        fire_req = 1'b1;
        ticks(10);
        fire_req = 1'b0;
        cyc();
        check("t4_acks", ack_cnt, 4);
        check("t4_drop_seen", int'(drop_cnt > 0), 1);
        check("t4_full", int'(bul_active), 15);

        // Head-on bullets cancel
        do_reset();
        fire(2, 4, 3, 0); ticks(2);
        fire(6, 4, 2, 0); ticks(1);
        check("t5_cancel", int'(bul_active), 0);
        check("t5_no_hit", hit_seen, 0);

        // Tick during scan replays once; reset mid-scan
        do_reset();
        fire(3, 3, 1, 0);
        move_tick = 1'b1; cyc(); cyc(); move_tick = 1'b0;
        repeat (12) cyc();
        check("t6_pending_y", int'(bul_y[PW-1:0]), 5);
        move_tick = 1'b1; cyc(); move_tick = 1'b0; cyc();
        check("t6_busy_before", int'(scan_busy), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("t6_rst_busy", int'(scan_busy), 0);
        check("t6_rst_active", int'(bul_active), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                for (int t = 0; t < NT; t++) set_tgt(t, $urandom_range(2, 9), $urandom_range(2, 9));
                tgt_alive = NT'($urandom_range(0, 31));
            end
            rst       = ($urandom_range(0, 599) == 0);
            move_tick = ($urandom_range(0, 5) == 0);
            fire_req  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                fire_x = PW'($urandom_range(0, MX));
                fire_y = PW'($urandom_range(0, MY));
            end else begin
                fire_x = PW'($urandom_range(2, 9));
                fire_y = PW'($urandom_range(2, 9));
            end
            fire_dir   = 2'($urandom_range(0, 3));
            fire_owner = TW'($urandom_range(0, NT - 1));
            cyc();
        end
        rst = 1'b0; move_tick = 1'b0; fire_req = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
